// File: rtl/fltr_evt_logger_pkg.sv
// Shared types and constants for the filtered-pulse event logger.
// FLTR_LOG_TSTAMP_EN adds a rising-edge timestamp field to each record.
package fltr_evt_logger_pkg;

   typedef logic [7:0] u8_t;

   localparam u8_t LEN_MAX   = 8'hFF;
   localparam int  LOG_CNT_W = 16;
   localparam int  LOG_TS_W  = 32;

`ifdef FLTR_LOG_TSTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HIGH = 1'b1
   } enLOG_STATE;

   // Record layout at the default widths; the logger builds the same layout
   // from its own parameters.
   typedef struct packed {
`ifdef FLTR_LOG_TSTAMP_EN
      logic [LOG_TS_W-1:0]  tstamp;
`endif
      logic [LOG_CNT_W-1:0] gap;
      u8_t                  len;
   } log_rec_t;

endpackage

// File: rtl/fltr_evt_logger_if.sv
// Record readout handshake: FWFT head fields qualified by evt_valid,
// consumed on evt_valid & evt_ready.
// FLTR_LOG_TSTAMP_EN adds the evt_tstamp field and the TS_W parameter.
interface fltr_evt_logger_if #(
   parameter int CNT_W = 16
`ifdef FLTR_LOG_TSTAMP_EN
   , parameter int TS_W = 32
`endif
);

   logic             evt_valid;
   logic             evt_ready;
   logic [CNT_W-1:0] evt_gap;
   logic [7:0]       evt_len;
`ifdef FLTR_LOG_TSTAMP_EN
   logic [TS_W-1:0]  evt_tstamp;
`endif

   modport master (
      input  evt_ready,
      output evt_valid,
      output evt_gap,
      output evt_len
`ifdef FLTR_LOG_TSTAMP_EN
      , output evt_tstamp
`endif
   );

   modport slave (
      output evt_ready,
      input  evt_valid,
      input  evt_gap,
      input  evt_len
`ifdef FLTR_LOG_TSTAMP_EN
      , input  evt_tstamp
`endif
   );

endinterface

// File: rtl/fltr_evt_logger_fifo.sv
// First-word-fall-through record FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle (the freed slot is reused).
module fltr_log_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rptr[AW-1:0]];

   // Pointer update; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading the pre-edge values.
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage write.
   // NOTE: the array is not reset; empty gates every use of its contents.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/fltr_evt_logger.sv
// Filtered-pulse event logger: measures each pulse's length and spacing from
// the previous rising edge, queues one record per pulse, keeps totals.
// FLTR_LOG_TSTAMP_EN adds a free-running timestamp captured at each rising edge.
module fltr_evt_logger
   import fltr_evt_logger_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int TS_W       = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fltr_in,
   fltr_evt_logger_if.master   evt,
   output logic [15:0]         evt_total,
   output u8_t                 drop_cnt,
   output logic                ovf
);

   localparam int TS_FIELD_W = TS_EN ? TS_W : 0;
   localparam int REC_W      = CNT_W + 8 + TS_FIELD_W;
   localparam logic [CNT_W-1:0] GAP_MAX = '1;

   typedef struct packed {
`ifdef FLTR_LOG_TSTAMP_EN
      logic [TS_W-1:0]  tstamp;
`endif
      logic [CNT_W-1:0] gap;
      u8_t              len;
   } rec_t;

   enLOG_STATE       state;
   enLOG_STATE       state_nxt;
   logic             prev_in;
   logic             rise;
   logic             fall;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] gap_cnt;
   logic [CNT_W-1:0] cur_gap;
   u8_t              len_cnt;
   rec_t             wr_rec;
   rec_t             rd_rec;
`ifdef FLTR_LOG_TSTAMP_EN
   logic [TS_W-1:0]  ts_cnt;
   logic [TS_W-1:0]  cur_ts;
`endif

   assign rise = fltr_in & ~prev_in;
   assign fall = ~fltr_in & prev_in;
   assign pop  = ~empty & evt.evt_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state and record push.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_nxt = state;
      push      = 1'b0;
      case (state)
         ST_IDLE: if (rise) state_nxt = ST_HIGH;
         ST_HIGH: if (fall) begin
            push      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Edge history, gap/length measurement and event total.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_in   <= 1'b1;
         gap_cnt   <= GAP_MAX;
         cur_gap   <= '0;
         len_cnt   <= '0;
         evt_total <= '0;
      end else begin
         prev_in <= fltr_in;
         if (rise) gap_cnt <= CNT_W'(1);
         else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + CNT_W'(1);
         if (state == ST_IDLE && rise) begin
            cur_gap   <= gap_cnt;
            len_cnt   <= 8'd1;
            evt_total <= evt_total + 16'd1;
         end else if (state == ST_HIGH && fltr_in && len_cnt != LEN_MAX) begin
            len_cnt <= len_cnt + 8'd1;
         end
      end
   end

`ifdef FLTR_LOG_TSTAMP_EN
   // Free-running timestamp, sampled at each accepted rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_cnt <= '0;
         cur_ts <= '0;
      end else begin
         ts_cnt <= ts_cnt + TS_W'(1);
         if (state == ST_IDLE && rise) cur_ts <= ts_cnt;
      end
   end
`endif

   // Drop accounting for pushes that find the FIFO full with no pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
         ovf      <= 1'b0;
      end else if (push && full && !pop) begin
         if (drop_cnt != LEN_MAX) drop_cnt <= drop_cnt + 8'd1;
         ovf <= 1'b1;
      end
   end

   // Record assembly.
   always_comb begin
      wr_rec     = '0;
      wr_rec.gap = cur_gap;
      wr_rec.len = len_cnt;
`ifdef FLTR_LOG_TSTAMP_EN
      wr_rec.tstamp = cur_ts;
`endif
   end

   fltr_log_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (wr_rec),
      .full  (full),
      .empty (empty),
      .dout  (rd_rec)
   );

   assign evt.evt_valid = ~empty;
   assign evt.evt_gap   = empty ? '0 : rd_rec.gap;
   assign evt.evt_len   = empty ? '0 : rd_rec.len;
`ifdef FLTR_LOG_TSTAMP_EN
   assign evt.evt_tstamp = empty ? '0 : rd_rec.tstamp;
`endif

endmodule
